rvcpu_mem_arbiter: RTL and testbench
====================================

// Module: rvcpu_mem_arbiter
// PURPOSE
//   Shares one single-port memory between the rvcpu instruction-fetch port and data port.
//   Arbitrates between the two requesters and sequences one memory transaction at a time.
//   Enforces a bus timeout so that rvcpu_top cannot hang before asserting halted.
//   Sits inside rvcpu_top, between cpu0 and the unified program/data memory.
// PARAMETERS
//   AW       32  address width, in bits (byte address)
//   DW       32  data width, in bits; byte strobe width is DW/8
//   TIMEOUT  64  cycles in BUSY without mem_ready before an error response; 0 disables the timeout
// PORTS
//   clk        in   1      clock; all state updates on the rising edge
//   rst_n      in   1      asynchronous, active-low reset
//   i_req      in   1      fetch request; held with i_addr until i_ready
//   i_addr     in   AW     fetch address
//   i_ready    out  1      fetch complete (1-cycle pulse)
//   i_rdata    out  DW     fetch data, valid while i_ready=1
//   d_req      in   1      data request; held with payload until d_ready
//   d_we       in   1      1=store, 0=load
//   d_addr     in   AW     data address
//   d_wdata    in   DW     store data
//   d_wstrb    in   DW/8   store byte strobes
//   d_ready    out  1      data access complete (1-cycle pulse)
//   d_rdata    out  DW     load data, valid while d_ready=1
//   bus_err    out  1      pulses with i_ready or d_ready when the access timed out
//   mem_req    out  1      memory request, held until mem_ready or timeout
//   mem_we     out  1      memory write enable
//   mem_addr   out  AW     memory address
//   mem_wdata  out  DW     memory write data
//   mem_wstrb  out  DW/8   memory byte strobes; all zero on reads
//   mem_ready  in   1      memory completion (1 cycle); ignored while mem_req=0
//   mem_rdata  in   DW     memory read data, valid with mem_ready
// BEHAVIOUR
//   Reset: state=IDLE, owner=I, last=I, cnt=0.
//   Reset outputs: mem_req=0, mem_we=0, mem_addr/wdata/wstrb=0, all ready, rdata and bus_err outputs=0.
//   Reset mid-transaction abandons the access; no ready pulse is produced.
//   State IDLE, one requester pending: grant it at the clock edge.
//     Latch its payload into mem_* registers, set owner, set last=owner, go to BUSY.
//     For a fetch grant: mem_we=0, mem_wstrb=0.
//   State IDLE, both pending: grant the requester != last. After reset, D therefore wins the first conflict.
//   State IDLE, neither pending: no change.
//   State BUSY: mem_req=1; mem_* outputs are stable registers.
//     Requester inputs are not sampled; changes to them are ignored.
//   State BUSY, mem_ready=1:
//     Owner's ready = mem_ready (combinational), owner's rdata = mem_rdata (combinational), bus_err=0.
//     The non-owner's ready stays 0.
//     At the edge: mem_req<=0, cnt<=0, state<=IDLE.
//   Timeout (TIMEOUT>0, BUSY, cnt==TIMEOUT-1, mem_ready=0):
//     Owner's ready=1, rdata=0, bus_err=1 for that cycle; then go to IDLE.
//   If mem_ready coincides with the timeout cycle, mem_ready wins and bus_err=0.
//   cnt increments each BUSY cycle without completion. Its width is clog2(TIMEOUT+1), so it never wraps.
//   The requester deasserts or changes req at the edge where it sees ready.
//   The arbiter always spends 1 IDLE cycle between transactions, so a new grant comes no earlier than 1 cycle after completion.
//   Latency: req seen in IDLE at edge t -> mem_req high t+1 -> ready in the same cycle as mem_ready.
//     Minimum is 1 cycle after grant.
//   d_we=1 with d_wstrb=0 is forwarded unchanged (no-op write).
// TESTING
//   1. i_req, addr 0x100, memory returns 0x00000013 after 2 cycles -> mem_req 1 cycle after grant, i_ready 1 cycle, i_rdata=0x13, bus_err=0.
//   2. i_req and d_req rise together right after reset -> D served first, then I.
//      With both held, grants alternate D,I,D,I across 4 transactions.
//   3. d_req store, addr 0x2004, wdata 0xDEADBEEF, wstrb 4'b0011 -> mem_we=1 and payload on mem_* unchanged; d_ready pulses; i_ready stays 0.
//   4. TIMEOUT=8, memory never ready -> after 8 BUSY cycles: d_ready=1, bus_err=1, d_rdata=0, mem_req drops; next request is granted normally.
//   5. mem_ready on the exact timeout cycle -> normal completion with real rdata, bus_err=0.
//   6. rst_n low mid-BUSY -> all outputs 0 immediately (asynchronous); after release a pending i_req is granted from IDLE.

Source files
------------

// File: rtl/rvcpu_mem_arbiter.sv
// Two-requester arbiter sharing one single-port memory between rvcpu fetch and data ports.
// One transaction at a time. A ready pulse goes back to the owner, or the access times out with bus_err.
module rvcpu_mem_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_req,
    input  logic [AW-1:0]   i_addr,
    output logic            i_ready,
    output logic [DW-1:0]   i_rdata,
    input  logic            d_req,
    input  logic            d_we,
    input  logic [AW-1:0]   d_addr,
    input  logic [DW-1:0]   d_wdata,
    input  logic [DW/8-1:0] d_wstrb,
    output logic            d_ready,
    output logic [DW-1:0]   d_rdata,
    output logic            bus_err,
    output logic            mem_req,
    output logic            mem_we,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    output logic [DW/8-1:0] mem_wstrb,
    input  logic            mem_ready,
    input  logic [DW-1:0]   mem_rdata
);
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t            state_reg;
    logic              owner_reg;   // 0 = fetch, 1 = data
    logic              last_reg;
    logic [CW-1:0]     cnt_reg;
    logic              mem_req_reg;
    logic              mem_we_reg;
    logic [AW-1:0]     mem_addr_reg;
    logic [DW-1:0]     mem_wdata_reg;
    logic [DW/8-1:0]   mem_wstrb_reg;

    logic busy;
    logic timeout_hit;
    logic done;
    logic pick_d;

    assign busy        = (state_reg == BUSY);
    assign timeout_hit = (TIMEOUT > 0) && busy && (cnt_reg == CNT_LAST);
    assign done        = busy && (mem_ready || timeout_hit);
    // On a conflict the requester that did not win last time is served.
    assign pick_d      = d_req && (!i_req || (last_reg == 1'b0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            owner_reg     <= 1'b0;
            last_reg      <= 1'b0;
            cnt_reg       <= '0;
            mem_req_reg   <= 1'b0;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
            mem_wstrb_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (i_req || d_req) begin
                        state_reg   <= BUSY;
                        owner_reg   <= pick_d;
                        last_reg    <= pick_d;
                        cnt_reg     <= '0;
                        mem_req_reg <= 1'b1;
                        if (pick_d) begin
                            mem_we_reg    <= d_we;
                            mem_addr_reg  <= d_addr;
                            mem_wdata_reg <= d_wdata;
                            mem_wstrb_reg <= d_we ? d_wstrb : '0;
                        end else begin
                            mem_we_reg    <= 1'b0;
                            mem_addr_reg  <= i_addr;
                            mem_wdata_reg <= '0;
                            mem_wstrb_reg <= '0;
                        end
                    end
                end
                BUSY: begin
                    if (done) begin
                        state_reg   <= IDLE;
                        mem_req_reg <= 1'b0;
                        cnt_reg     <= '0;
                    end else if (cnt_reg != '1) begin
                        // Saturating, so a disabled timeout never wraps the counter.
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign mem_req   = mem_req_reg;
    assign mem_we    = mem_we_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;
    assign mem_wstrb = mem_wstrb_reg;

    // A real completion beats a coincident timeout, so rdata is forwarded only with mem_ready.
    assign i_ready = done && !owner_reg;
    assign d_ready = done &&  owner_reg;
    assign i_rdata = (busy && !owner_reg && mem_ready) ? mem_rdata : '0;
    assign d_rdata = (busy &&  owner_reg && mem_ready) ? mem_rdata : '0;
    assign bus_err = timeout_hit && !mem_ready;

endmodule

// File: tb/tb_rvcpu_mem_arbiter.sv
// Directed bench for rvcpu_mem_arbiter with TIMEOUT=8.
// Inputs change on the falling edge, and outputs are checked 1 time unit later.
module tb_rvcpu_mem_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          i_req;
    logic [AW-1:0] i_addr;
    logic          i_ready;
    logic [DW-1:0] i_rdata;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [3:0]    d_wstrb;
    logic          d_ready;
    logic [DW-1:0] d_rdata;
    logic          bus_err;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [3:0]    mem_wstrb;
    logic          mem_ready;
    logic [DW-1:0] mem_rdata;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    rvcpu_mem_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
        .d_ready(d_ready), .d_rdata(d_rdata), .bus_err(bus_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
        end else begin
            $display("ok   %s = %0h", tag, obs);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    logic [AW-1:0] exp_addr [4] = '{32'h80, 32'h40, 32'h80, 32'h40};
    logic          exp_d    [4] = '{1'b1, 1'b0, 1'b1, 1'b0};

    initial begin
        i_req = 0; i_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0; d_wstrb = 0;
        mem_ready = 0; mem_rdata = 0;
        @(negedge clk);
        do_reset();
        #1;
        chk("rst mem_req", mem_req, 0);
        chk("rst mem_addr", mem_addr, 0);
        chk("rst i_ready", i_ready, 0);
        chk("rst d_ready", d_ready, 0);
        chk("rst bus_err", bus_err, 0);

        // 1: fetch, memory answers on the 2nd BUSY cycle
        i_req = 1; i_addr = 32'h100;
        step(); #1;
        chk("t1 mem_req", mem_req, 1);
        chk("t1 mem_addr", mem_addr, 32'h100);
        chk("t1 mem_we", mem_we, 0);
        chk("t1 mem_wstrb", mem_wstrb, 0);
        chk("t1 i_ready wait", i_ready, 0);
        step();
        mem_ready = 1; mem_rdata = 32'h13; #1;
        chk("t1 i_ready", i_ready, 1);
        chk("t1 i_rdata", i_rdata, 32'h13);
        chk("t1 bus_err", bus_err, 0);
        chk("t1 d_ready", d_ready, 0);
        i_req = 0;
        step();
        mem_ready = 0; #1;
        chk("t1 idle mem_req", mem_req, 0);
        chk("t1 idle i_ready", i_ready, 0);

        // 2: simultaneous requests after reset, alternation D,I,D,I
        do_reset();
        i_req = 1; i_addr = 32'h40; d_req = 1; d_we = 0; d_addr = 32'h80;
        for (int k = 0; k < 4; k++) begin
            step(); #1;
            chk($sformatf("t2.%0d mem_addr", k), mem_addr, exp_addr[k]);
            mem_ready = 1; mem_rdata = 32'h1000 + k; #1;
            chk($sformatf("t2.%0d d_ready", k), d_ready, exp_d[k]);
            chk($sformatf("t2.%0d i_ready", k), i_ready, !exp_d[k]);
            step();
            mem_ready = 0; #1;
            chk($sformatf("t2.%0d idle mem_req", k), mem_req, 0);
        end
        i_req = 0; d_req = 0;
        step();

        // 3: store with partial strobes, payload held stable while BUSY
        d_req = 1; d_we = 1; d_addr = 32'h2004; d_wdata = 32'hDEADBEEF; d_wstrb = 4'b0011;
        step(); #1;
        chk("t3 mem_we", mem_we, 1);
        chk("t3 mem_addr", mem_addr, 32'h2004);
        chk("t3 mem_wdata", mem_wdata, 32'hDEADBEEF);
        chk("t3 mem_wstrb", mem_wstrb, 4'b0011);
        d_addr = 32'hFFFF0000; d_wstrb = 4'b1111;
        step(); #1;
        chk("t3 hold addr", mem_addr, 32'h2004);
        chk("t3 hold wstrb", mem_wstrb, 4'b0011);
        mem_ready = 1; #1;
        chk("t3 d_ready", d_ready, 1);
        chk("t3 i_ready", i_ready, 0);
        chk("t3 bus_err", bus_err, 0);
        d_req = 0; d_we = 0;
        step();
        mem_ready = 0;

        // 4: timeout after 8 BUSY cycles, then a normal grant
        d_req = 1; d_addr = 32'h300; mem_rdata = 32'hAAAA5555;
        for (int k = 1; k <= 8; k++) begin
            step(); #1;
            if (k < 8) chk($sformatf("t4 c%0d d_ready", k), d_ready, 0);
        end
        chk("t4 d_ready", d_ready, 1);
        chk("t4 bus_err", bus_err, 1);
        chk("t4 d_rdata", d_rdata, 0);
        d_req = 0;
        step(); #1;
        chk("t4 mem_req drop", mem_req, 0);
        chk("t4 bus_err drop", bus_err, 0);
        i_req = 1; i_addr = 32'h500;
        step(); #1;
        chk("t4 regrant mem_req", mem_req, 1);
        chk("t4 regrant addr", mem_addr, 32'h500);
        mem_ready = 1; mem_rdata = 32'h77; #1;
        chk("t4 regrant i_rdata", i_rdata, 32'h77);
        i_req = 0;
        step();
        mem_ready = 0;

        // 5: mem_ready on the timeout cycle wins
        d_req = 1; d_addr = 32'h600;
        for (int k = 1; k <= 8; k++) step();
        mem_ready = 1; mem_rdata = 32'h55; #1;
        chk("t5 d_ready", d_ready, 1);
        chk("t5 d_rdata", d_rdata, 32'h55);
        chk("t5 bus_err", bus_err, 0);
        d_req = 0;
        step();
        mem_ready = 0;

        // 6: asynchronous reset mid-BUSY
        i_req = 1; i_addr = 32'h700;
        step();
        step();
        mem_ready = 1; mem_rdata = 32'h99;
        #1 rst_n = 0;
        #1;
        chk("t6 mem_req", mem_req, 0);
        chk("t6 mem_addr", mem_addr, 0);
        chk("t6 i_ready", i_ready, 0);
        chk("t6 i_rdata", i_rdata, 0);
        @(negedge clk);
        mem_ready = 0; rst_n = 1;
        step(); #1;
        chk("t6 regrant mem_req", mem_req, 1);
        chk("t6 regrant addr", mem_addr, 32'h700);
        i_req = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
